// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
// Latency: n/a (declarations and pure helper functions only).
// Backpressure: n/a.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
  } state_t;

  // Opcodes recognised by the decoder
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // Immediate extender selects
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // ALU operation classes handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  // ALU control encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Moore output bundle held in a register alongside the state
  typedef struct packed {
    logic       adrsrc;
    logic       irwrite;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] resultsrc;
    logic       pcupdate;
    logic       branch;
    logic       regwrite;
    logic       memwrite;
  } ctl_t;

  // Per-state control values; anything not set stays 0
  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.irwrite = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10; c.pcupdate = 1'b1; end
      DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; end
      MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
      MEMREAD:  begin c.adrsrc = 1'b1; end
      MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
      MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
      EXECUTER: begin c.alusrca = 2'b10; c.aluop = ALUOP_FUNC; end
      EXECUTEI: begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = ALUOP_FUNC; end
      ALUWB:    begin c.regwrite = 1'b1; end
      BEQ:      begin c.alusrca = 2'b10; c.aluop = ALUOP_SUB; c.branch = 1'b1; end
      JAL:      begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcupdate = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  // Opcode is only consulted in DECODE and MEMADR
  function automatic state_t next_state(input state_t s, input logic [6:0] op);
    state_t n;
    n = FETCH;
    case (s)
      FETCH: n = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: n = MEMADR;
          OP_RTYPE:     n = EXECUTER;
          OP_ITYPE:     n = EXECUTEI;
          OP_BEQ:       n = BEQ;
          OP_JAL:       n = JAL;
          default:      n = FETCH;
        endcase
      end
      MEMADR:   n = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  n = MEMWB;
      EXECUTER: n = ALUWB;
      EXECUTEI: n = ALUWB;
      JAL:      n = ALUWB;
      default:  n = FETCH;
    endcase
    return n;
  endfunction

  // Immediate format follows the opcode regardless of state
  function automatic logic [1:0] imm_of(input logic [6:0] op);
    logic [1:0] i;
    case (op)
      OP_SW:   i = IMM_S;
      OP_BEQ:  i = IMM_B;
      OP_JAL:  i = IMM_J;
      default: i = IMM_I;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps ALU operation class plus funct fields to an ALU control code.
// Latency: purely combinational.
// Backpressure: none.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  // Subtract only for R-type with funct7[5] set; I-type add has no sub form
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM driving datapath selects and write strobes.
// Latency: 2..5 cycles per instruction; pcwrite follows zero combinationally.
// Backpressure: none; the FSM advances every cycle outside reset.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic [2:0] alucontrol,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite
);

  state_t state;
  ctl_t   ctl_q;
  ctl_t   ctl;

  // State register; Moore outputs are registered for the state being entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      ctl_q <= ctl_of(FETCH);
    end else begin
      state <= next_state(state, op);
      ctl_q <= ctl_of(next_state(state, op));
    end
  end

  // While reset is low, selects show FETCH values and all strobes are quiet
  always_comb begin
    ctl = ctl_q;
    if (!rst_n) begin
      ctl          = ctl_of(FETCH);
      ctl.irwrite  = 1'b0;
      ctl.pcupdate = 1'b0;
      ctl.branch   = 1'b0;
      ctl.regwrite = 1'b0;
      ctl.memwrite = 1'b0;
    end
  end

  assign immsrc    = imm_of(op);
  assign alusrca   = ctl.alusrca;
  assign alusrcb   = ctl.alusrcb;
  assign resultsrc = ctl.resultsrc;
  assign adrsrc    = ctl.adrsrc;
  assign irwrite   = ctl.irwrite;
  assign regwrite  = ctl.regwrite;
  assign memwrite  = ctl.memwrite;
  assign pcwrite   = ctl.pcupdate | (ctl.branch & zero);

  alu_decoder u_alu_decoder (
    .aluop      (ctl.aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed vector table, reset corner cases,
// and random instruction streams against an instruction-level model.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
  logic       adrsrc;
  logic [2:0] alucontrol;
  logic       irwrite, pcwrite, regwrite, memwrite;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  typedef struct packed {
    logic       irwrite, pcwrite, regwrite, memwrite, adrsrc;
    logic [1:0] alusrca, alusrcb, resultsrc, immsrc;
    logic [2:0] alucontrol;
  } vec_t;

  typedef struct {
    string      nm;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         cyc;
    vec_t       exp;
  } vrec_t;

  vec_t got;
  assign got = {irwrite, pcwrite, regwrite, memwrite, adrsrc,
                alusrca, alusrcb, resultsrc, immsrc, alucontrol};

  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .immsrc(immsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .resultsrc(resultsrc), .adrsrc(adrsrc), .alucontrol(alucontrol),
    .irwrite(irwrite), .pcwrite(pcwrite), .regwrite(regwrite), .memwrite(memwrite)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(bit ir, bit pw, bit rw, bit mw, bit ad,
                             bit [1:0] a, bit [1:0] b, bit [1:0] r, bit [1:0] i, bit [2:0] alu);
    vec_t x;
    x = {ir, pw, rw, mw, ad, a, b, r, i, alu};
    return x;
  endfunction

  // ---------- instruction-level reference model ----------
  function automatic int len_of(logic [6:0] o);
    case (o)
      LW: return 5;
      SW, RT, IT, JL: return 4;
      BQ: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] imm_ref(logic [6:0] o);
    case (o)
      SW: return 2'b01;
      BQ: return 2'b10;
      JL: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] func_ref(logic [2:0] f3, logic op5, logic f7);
    case (f3)
      3'd0: return (op5 & f7) ? 3'b001 : 3'b000;
      3'd2: return 3'b101;
      3'd6: return 3'b011;
      3'd7: return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs for cycle c (0 = fetch) of instruction o
  function automatic vec_t model(logic [6:0] o, logic [2:0] f3, logic f7, logic z, int c);
    vec_t x;
    x = '0;
    x.immsrc = imm_ref(o);
    if (c == 0) begin
      x.irwrite = 1; x.pcwrite = 1; x.alusrcb = 2'b10; x.resultsrc = 2'b10;
    end else if (c == 1) begin
      x.alusrca = 2'b01; x.alusrcb = 2'b01;
    end else begin
      case (o)
        LW: if (c == 2) begin x.alusrca = 2'b10; x.alusrcb = 2'b01; end
            else if (c == 3) x.adrsrc = 1;
            else begin x.resultsrc = 2'b01; x.regwrite = 1; end
        SW: if (c == 2) begin x.alusrca = 2'b10; x.alusrcb = 2'b01; end
            else begin x.adrsrc = 1; x.memwrite = 1; end
        RT, IT: if (c == 2) begin
              x.alusrca = 2'b10;
              x.alusrcb = (o == IT) ? 2'b01 : 2'b00;
              x.alucontrol = func_ref(f3, o[5], f7);
            end else x.regwrite = 1;
        BQ: begin x.alusrca = 2'b10; x.alucontrol = 3'b001; x.pcwrite = z; end
        JL: if (c == 2) begin x.alusrca = 2'b01; x.alusrcb = 2'b10; x.pcwrite = 1; end
            else x.regwrite = 1;
        default: x = x;
      endcase
    end
    return x;
  endfunction

  task automatic chk(input string nm, input logic [15:0] g, input logic [15:0] w);
    total++;
    if (g !== w) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, g, w);
    end
  endtask

  // Runs one instruction starting just after the edge that entered FETCH.
  // zmode: 0/1 fixed zero, 2 random per cycle. Table check at cycle tc.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int zmode, input string nm, input int tc, input vec_t texp);
    int n;
    n = len_of(o);
    op = o; funct3 = f3; funct7b5 = f7;
    for (int c = 0; c < n; c++) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      @(negedge clk);
      chk($sformatf("%s_cyc%0d", nm, c), got, model(o, f3, f7, zero, c));
      if (c == tc) chk($sformatf("%s_vec", nm), got, texp);
      @(posedge clk); #1;
    end
  endtask

  vrec_t tbl[$];
  vec_t  rst_vec;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] o;
    int k;
    rst_n = 0; op = 7'd0; funct3 = 3'd0; funct7b5 = 0; zero = 1;
    rst_vec = v(0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00,3'b000);

    tbl.push_back('{"lw_fetch", LW, 3'd0, 0, 0, 0, v(1,1,0,0,0, 2'b00,2'b10,2'b10,2'b00,3'b000)});
    tbl.push_back('{"lw_memread", LW, 3'd0, 0, 0, 3, v(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000)});
    tbl.push_back('{"lw_memwb", LW, 3'd0, 0, 0, 4, v(0,0,1,0,0, 2'b00,2'b00,2'b01,2'b00,3'b000)});
    tbl.push_back('{"sw_memadr", SW, 3'd2, 0, 0, 2, v(0,0,0,0,0, 2'b10,2'b01,2'b00,2'b01,3'b000)});
    tbl.push_back('{"sw_memwrite", SW, 3'd2, 0, 0, 3, v(0,0,0,1,1, 2'b00,2'b00,2'b00,2'b01,3'b000)});
    tbl.push_back('{"beq_taken", BQ, 3'd0, 0, 1, 2, v(0,1,0,0,0, 2'b10,2'b00,2'b00,2'b10,3'b001)});
    tbl.push_back('{"beq_nottaken", BQ, 3'd0, 0, 0, 2, v(0,0,0,0,0, 2'b10,2'b00,2'b00,2'b10,3'b001)});
    tbl.push_back('{"r_decode", RT, 3'd0, 1, 0, 1, v(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00,3'b000)});
    tbl.push_back('{"r_sub", RT, 3'd0, 1, 0, 2, v(0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00,3'b001)});
    tbl.push_back('{"r_slt", RT, 3'd2, 0, 0, 2, v(0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00,3'b101)});
    tbl.push_back('{"r_or", RT, 3'd6, 0, 0, 2, v(0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00,3'b011)});
    tbl.push_back('{"r_and", RT, 3'd7, 1, 0, 2, v(0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00,3'b010)});
    tbl.push_back('{"r_aluwb", RT, 3'd7, 1, 0, 3, v(0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000)});
    tbl.push_back('{"i_addi_f7", IT, 3'd0, 1, 0, 2, v(0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00,3'b000)});
    tbl.push_back('{"jal_state", JL, 3'd0, 0, 0, 2, v(0,1,0,0,0, 2'b01,2'b10,2'b00,2'b11,3'b000)});
    tbl.push_back('{"jal_aluwb", JL, 3'd0, 0, 0, 3, v(0,0,1,0,0, 2'b00,2'b00,2'b00,2'b11,3'b000)});
    tbl.push_back('{"illegal_decode", 7'h7f, 3'd0, 0, 1, 1, v(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00,3'b000)});
    tbl.push_back('{"after_illegal", LW, 3'd0, 0, 1, 0, v(1,1,0,0,0, 2'b00,2'b10,2'b10,2'b00,3'b000)});

    // Reset: outputs gated while low, FETCH on release
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_hold", got, rst_vec);
    @(posedge clk); #1;
    rst_n = 1;

    foreach (tbl[i])
      run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, int'(tbl[i].z), tbl[i].nm, tbl[i].cyc, tbl[i].exp);

    // Reset asserted in MEMREAD and held for two edges
    op = LW; funct3 = 0; funct7b5 = 0; zero = 1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("pre_reset_memread", got, v(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000));
    rst_n = 0; #1;
    chk("reset_comb_memread", got, rst_vec);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_second_cycle", got, rst_vec);
    @(posedge clk); #1;
    rst_n = 1;
    run_instr(LW, 3'd0, 0, 0, "post_reset_lw", 0, v(1,1,0,0,0, 2'b00,2'b10,2'b10,2'b00,3'b000));

    // Opcode changing outside DECODE/MEMADR must not alter the path
    op = RT; funct3 = 3'd0; funct7b5 = 0; zero = 0;
    repeat (3) begin @(posedge clk); #1; end
    op = SW;
    @(negedge clk);
    chk("opchg_aluwb_strobes", {11'd0, got[15:11]}, 16'b00100);
    @(posedge clk); #1;
    op = 7'h7f;
    @(negedge clk);
    chk("opchg_back_to_fetch", {11'd0, got[15:11]}, 16'b11000);
    @(posedge clk); #1;
    op = 7'h7f; zero = 1;
    @(negedge clk);
    chk("opchg_illegal_decode", {11'd0, got[15:11]}, 16'b00000);
    @(posedge clk); #1;

    // Random instruction stream
    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 6);
      case (k)
        0: o = LW; 1: o = SW; 2: o = RT; 3: o = IT; 4: o = BQ; 5: o = JL;
        default: begin
          o = 7'($urandom_range(0, 127));
          if (o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL) o = 7'h00;
        end
      endcase
      run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2,
                $sformatf("rnd%0d_op%02h", n, o), -1, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
